mips_cache_controller: RTL and testbench
========================================

# mips_cache_controller

Memory-side responder for the CPU's instruction and data caches. It accepts miss and write-through requests from both caches, arbitrates them onto a single Avalon-style memory master port, and returns each fetched word to the requesting cache with a one-cycle valid pulse. It sits between the two caches and the top-level memory bus.

## Interface
- MAX_WAIT, 255: memory wait cycles tolerated per transaction before `mem_error` sets. A value of 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- instr_stall  in  1  instruction cache miss; the request is present while high.
- instr_addr  in  32  instruction miss byte address.
- instr_data  out  32  fetched instruction word.
- instr_data_valid  out  1  one-cycle pulse; `instr_data` is valid during this cycle.
- data_stall  in  1  data cache request present.
- data_write  in  1  request type when `data_stall` is high: 1 = write-through, 0 = read fill.
- data_addr  in  32  data byte address.
- data_writedata  in  32  write data.
- data_byteenable  in  4  write byte enables.
- data_data  out  32  fetched data word; zero after a write.
- data_data_valid  out  1  one-cycle pulse; the read or write is complete.
- mem_address  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- mem_read  out  1  Avalon read.
- mem_write  out  1  Avalon write.
- mem_writedata  out  32  Avalon write data.
- mem_byteenable  out  4  Avalon byte enables; 4'b1111 for reads.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  32  valid in the cycle where `mem_read`=1 and `mem_waitrequest`=0.
- mem_error  out  1  sticky timeout flag.

## Operation
- State machine states:
  - IDLE
  - MEM_I: instruction read in flight.
  - MEM_D: data read or write in flight.
  - RESP: pulse valid to the owning cache.
- IDLE arbitration, sampled each cycle:
  - `data_stall` wins over `instr_stall` (fixed priority; the MEM stage is older than IF).
  - The winner's address, type, writedata and byteenable are latched into request registers.
  - Move to MEM_D or MEM_I.
- MEM_I / MEM_D:
  - Drive `mem_read` or `mem_write` from the latched registers. Do not drive from the live cache inputs.
  - Hold the command until a cycle with `mem_waitrequest`=0. That cycle completes the transfer.
  - On completion, latch `mem_readdata` (reads) into the owner's data register, drop the command and go to RESP.
- RESP:
  - Assert the owner's `*_data_valid` for exactly one cycle. The other valid stays low.
  - Always return to IDLE. No request is accepted in RESP, because the cache updates on this edge and lowers its stall next cycle.
- Timeout:
  - A wait counter, width 8 or $clog2(MAX_WAIT+1), counts cycles in MEM_* with waitrequest high.
  - When the count reaches MAX_WAIT and MAX_WAIT≠0, set `mem_error`. The transfer keeps waiting; the flag only reports.
  - `mem_error` clears only on rst.
- Cache request inputs are ignored outside IDLE. Input changes after latching do not alter the transaction in flight.

## Timing
- Reset (async, immediate):
  - State forced to IDLE; any in-flight transfer is abandoned.
  - All outputs go to 0: mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, both data buses, both valids, mem_error.
  - Reset mid-transfer must drop `mem_read`/`mem_write` in the same cycle `rst` rises, with no clock edge needed.
- All outputs are registered or decoded from registered state. There is no combinational path from cache inputs to mem_* outputs.
- Zero-wait read latency: request seen in IDLE at edge N, `mem_read` high in cycle N+1, data latched at edge N+2, `*_data_valid` high in cycle N+2→N+3. The cache fills at edge N+3. Minimum request-to-next-accept is 4 cycles.
- Each waitrequest cycle adds one cycle.
- Simultaneous requests: data is served first. The instruction request, if still asserted, is accepted in the IDLE cycle after RESP.
- A back-to-back instruction miss is served in turn, with no starvation of IF once the data stall clears.

## Structure
- Shared package `mips_cache_pkg` holds:
  - state enum `ctrl_state_t` {IDLE, MEM_I, MEM_D, RESP};
  - owner encoding `OWNER_I`=0, `OWNER_D`=1;
  - `WORD_ALIGN_MASK` = 32'hFFFF_FFFC.
- No sub-module. The arbiter, FSM and timeout counter are one always_ff plus output decode.

## Test plan
- Instruction miss, instr_addr=0xBFC0_0004, waitrequest=0, readdata=0x2402_0005 → mem_read with mem_address=0xBFC0_0004 for 1 cycle; instr_data=0x2402_0005 with instr_data_valid for exactly 1 cycle; data_data_valid stays 0.
- Both stalls in the same cycle (data read 0x1000_0008 → 0xDEAD_BEEF; instr 0xBFC0_0000 → 0x0000_0000) → data transaction first, then instruction; valid pulses 4 cycles apart with zero wait.
- Data write, addr=0x1000_0013, writedata=0x0000_00AB, byteenable=4'b1000, waitrequest high for 3 cycles → mem_write held 4 cycles at mem_address=0x1000_0010 with byteenable 1000; then a data_data_valid pulse.
- MAX_WAIT=4 with waitrequest held high for 10 cycles → mem_error rises after 4 wait cycles and stays high after the transfer completes; it clears only on rst.
- rst asserted asynchronously mid MEM_I (between clock edges) → mem_read drops immediately and all outputs read 0; after release, the stalled request is re-served from IDLE.
- instr_addr changed while in MEM_I → mem_address stays at the latched value until RESP.

Source files
------------

// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the cache-to-memory controller.
package mips_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } ctrl_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mips_cache_controller.sv
// Memory-side responder for the instruction and data caches. Arbitrates
// cache requests onto one Avalon-style master port and returns each word
// to the requesting cache with a one-cycle valid pulse.
//
//  state | meaning
//  IDLE  | arbitrate; data request beats instruction request
//  MEM_I | instruction read in flight
//  MEM_D | data read or write in flight
//  RESP  | valid pulse to the owning cache; no new request taken
//
// The request is latched on the accepting edge and the bus command is
// issued one edge later, so every mem_* output comes only from flops.
module mips_cache_controller
    import mips_cache_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_stall,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        instr_data_valid,
    input  logic        data_stall,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_data,
    output logic        data_data_valid,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        mem_error
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    ctrl_state_t state;
    logic        owner;
    logic        req_write;
    logic [7:0]  wait_cnt;

    // Arbiter, transfer FSM and timeout counter in one registered process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            owner            <= OWNER_I;
            req_write        <= 1'b0;
            wait_cnt         <= 8'd0;
            instr_data       <= 32'd0;
            instr_data_valid <= 1'b0;
            data_data        <= 32'd0;
            data_data_valid  <= 1'b0;
            mem_address      <= 32'd0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            mem_writedata    <= 32'd0;
            mem_byteenable   <= 4'd0;
            mem_error        <= 1'b0;
        end else begin
            instr_data_valid <= 1'b0;
            data_data_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_stall) begin
                        owner          <= OWNER_D;
                        req_write      <= data_write;
                        mem_address    <= word_align(data_addr);
                        mem_writedata  <= data_write ? data_writedata : 32'd0;
                        mem_byteenable <= data_write ? data_byteenable : 4'hF;
                        state          <= MEM_D;
                    end else if (instr_stall) begin
                        owner          <= OWNER_I;
                        req_write      <= 1'b0;
                        mem_address    <= word_align(instr_addr);
                        mem_writedata  <= 32'd0;
                        mem_byteenable <= 4'hF;
                        state          <= MEM_I;
                    end
                end
                MEM_I, MEM_D: begin
                    if (!mem_read && !mem_write) begin
                        mem_read  <= ~req_write;
                        mem_write <= req_write;
                        wait_cnt  <= 8'd0;
                    end else if (!mem_waitrequest) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner == OWNER_D) begin
                            data_data       <= req_write ? 32'd0 : mem_readdata;
                            data_data_valid <= 1'b1;
                        end else begin
                            instr_data       <= mem_readdata;
                            instr_data_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        // Saturating count; the flag only reports, the transfer keeps waiting.
                        if (wait_cnt != MAX_W) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                        if ((MAX_W != 8'd0) && (wait_cnt == MAX_W - 8'd1)) begin
                            mem_error <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cache_controller.sv
// Self-checking bench for mips_cache_controller: directed cases plus a
// randomized series of cache requests against a transaction-level model.
module tb_mips_cache_controller;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_stall = 1'b0;
    logic [31:0] instr_addr = 32'd0;
    logic [31:0] instr_data;
    logic        instr_data_valid;
    logic        data_stall = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_writedata = 32'd0;
    logic [3:0]  data_byteenable = 4'd0;
    logic [31:0] data_data;
    logic        data_data_valid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'd0;
    logic        mem_error;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    int e_start     = 0;
    bit err_sticky  = 0;

    mips_cache_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_stall      (instr_stall),
        .instr_addr       (instr_addr),
        .instr_data       (instr_data),
        .instr_data_valid (instr_data_valid),
        .data_stall       (data_stall),
        .data_write       (data_write),
        .data_addr        (data_addr),
        .data_writedata   (data_writedata),
        .data_byteenable  (data_byteenable),
        .data_data        (data_data),
        .data_data_valid  (data_data_valid),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_byteenable   (mem_byteenable),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_error        (mem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Acts as the memory slave for one transaction and checks the cache-side response.
    task automatic serve(input bit is_d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] rdata, input int w, output int lat);
        int n;
        int cmd_cycles;
        int waited;
        bit prev_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        lat = -1;
        exp_addr = {addr[31:2], 2'b00};
        n = 0;
        while (!(mem_read || mem_write) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_seen", 32'(mem_read | mem_write), 32'd1);
        if (!(mem_read || mem_write)) return;
        chk("mem_address", mem_address, exp_addr);
        chk("mem_read", 32'(mem_read), 32'(!wr));
        chk("mem_write", 32'(mem_write), 32'(wr));
        chk("mem_byteenable", 32'(mem_byteenable), wr ? 32'(be) : 32'hF);
        if (wr) chk("mem_writedata", mem_writedata, wd);
        mem_readdata    = wr ? $urandom : rdata;
        mem_waitrequest = (w > 0);
        if (is_d) begin
            data_addr       = $urandom;
            data_writedata  = $urandom;
            data_byteenable = 4'($urandom);
            data_write      = 1'($urandom);
        end else begin
            instr_addr = $urandom;
        end
        cmd_cycles = 1;
        waited = 0;
        while (1) begin
            prev_wr = mem_waitrequest;
            @(negedge clk);
            if (prev_wr) waited++;
            chk("mem_error", 32'(mem_error), 32'(err_sticky || (MAX_WAIT != 0 && waited >= MAX_WAIT)));
            if (!(mem_read || mem_write)) break;
            cmd_cycles++;
            chk("addr_hold", mem_address, exp_addr);
            mem_waitrequest = (cmd_cycles <= w);
            if (cmd_cycles > w + 4) break;
        end
        chk("cmd_len", 32'(cmd_cycles), 32'(w + 1));
        if (MAX_WAIT != 0 && w >= MAX_WAIT) err_sticky = 1;
        mem_waitrequest = 0;
        lat = edge_cnt - e_start;
        exp_data = wr ? 32'd0 : rdata;
        if (is_d) begin
            chk("data_valid", 32'(data_data_valid), 32'd1);
            chk("instr_valid_quiet", 32'(instr_data_valid), 32'd0);
            chk("data_data", data_data, exp_data);
            data_stall = 0;
        end else begin
            chk("instr_valid", 32'(instr_data_valid), 32'd1);
            chk("data_valid_quiet", 32'(data_data_valid), 32'd0);
            chk("instr_data", instr_data, exp_data);
            instr_stall = 0;
        end
        @(negedge clk);
        chk("valid_pulse_end", 32'({instr_data_valid, data_data_valid}), 32'd0);
    endtask

    // Presents one set of cache requests; data is served first, then instruction.
    task automatic run(input bit do_d, input bit d_wr, input logic [31:0] d_addr,
                       input logic [31:0] d_wd, input logic [3:0] d_be,
                       input logic [31:0] d_rd, input int wd_,
                       input bit do_i, input logic [31:0] i_addr,
                       input logic [31:0] i_rd, input int wi);
        int lat1;
        int lat2;
        data_write      = d_wr;
        data_addr       = d_addr;
        data_writedata  = d_wd;
        data_byteenable = d_be;
        instr_addr      = i_addr;
        data_stall      = do_d;
        instr_stall     = do_i;
        e_start = edge_cnt;
        if (do_d) begin
            serve(1'b1, d_wr, d_addr, d_wd, d_be, d_rd, wd_, lat1);
            chk("lat_data", 32'(lat1), 32'(3 + wd_));
            if (do_i) begin
                serve(1'b0, 1'b0, i_addr, 32'd0, 4'hF, i_rd, wi, lat2);
                chk("lat_instr_after_data", 32'(lat2), 32'(lat1 + 4 + wi));
            end
        end else if (do_i) begin
            serve(1'b0, 1'b0, i_addr, 32'd0, 4'hF, i_rd, wi, lat1);
            chk("lat_instr", 32'(lat1), 32'(3 + wi));
        end else begin
            @(negedge clk);
            @(negedge clk);
            chk("idle_no_cmd", 32'(mem_read | mem_write), 32'd0);
        end
        data_stall  = 0;
        instr_stall = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_writedata"}, mem_writedata, 32'd0);
        chk({tag, "_mem_byteenable"}, 32'(mem_byteenable), 32'd0);
        chk({tag, "_instr_data"}, instr_data, 32'd0);
        chk({tag, "_data_data"}, data_data, 32'd0);
        chk({tag, "_valids"}, 32'({instr_data_valid, data_data_valid}), 32'd0);
        chk({tag, "_mem_error"}, 32'(mem_error), 32'd0);
    endtask

    initial begin
        int n;
        bit rd_d, rd_i, rw;
        rst = 1;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 0;
        @(negedge clk);

        // Single instruction miss, zero wait.
        run(0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1, 32'hBFC0_0004, 32'h2402_0005, 0);
        chk("dvalid_idle", 32'(data_data_valid), 32'd0);

        // Simultaneous requests: data first, instruction four cycles later.
        run(1, 0, 32'h1000_0008, 32'd0, 4'd0, 32'hDEAD_BEEF, 0, 1, 32'hBFC0_0000, 32'h0000_0000, 0);

        // Unaligned write-through with three wait cycles.
        run(1, 1, 32'h1000_0013, 32'h0000_00AB, 4'b1000, 32'd0, 3, 0, 32'd0, 32'd0, 0);

        // Randomized traffic, waits below the timeout.
        for (int k = 0; k < 30; k++) begin
            rd_d = 1'($urandom);
            rd_i = 1'($urandom);
            rw   = 1'($urandom);
            run(rd_d, rw, $urandom, $urandom, 4'($urandom), $urandom,
                int'($urandom_range(0, 3)),
                rd_i, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // Timeout: ten wait cycles; flag rises after four and stays set.
        run(0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1, 32'h0040_0100, 32'hCAFE_F00D, 10);
        run(1, 0, 32'h1000_0020, 32'd0, 4'd0, 32'h1234_5678, 0, 0, 32'd0, 32'd0, 0);
        chk("error_sticky", 32'(mem_error), 32'd1);

        // Asynchronous reset between clock edges in the middle of an instruction read.
        instr_addr  = 32'h0040_0200;
        instr_stall = 1;
        n = 0;
        while (!mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_read", 32'(mem_read), 32'd1);
        #2;
        rst = 1;
        #1;
        chk_all_zero("async_reset");
        err_sticky = 0;
        @(negedge clk);
        rst = 0;
        run(0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1, 32'h0040_0200, 32'h8C43_0000, 1);
        chk("error_after_reset", 32'(mem_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
